// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OUT_BUF_DEPTH  = 3;
  localparam int PTR_W          = 2;
  localparam int BEAT_CNT_W     = 16;

  // Pointers cover 0..OUT_BUF_DEPTH-1 and wrap back to 0.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Three-entry circular output buffer: push from the FIFO return path, pop to the stream.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [PTR_W-1:0]      occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [OUT_BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // A return word arriving now is dropped; a pop now needs no bookkeeping.
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   occ <= occ + PTR_W'(1);
        2'b01:   occ <= occ - PTR_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign valid = (occ != '0);
  assign data  = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream with a 3-deep skid buffer.
// Optional packet-boundary flag m_last is built when FIFO_RD_LAST_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_pkt_len_check
    $error("fifo_stream_reader: PKT_LEN must be in 1..65535");
  end

  logic             inflight;
  logic [PTR_W-1:0] occ;
  logic             pop;

  // Reserve a slot for every outstanding read so a returning word always fits.
  assign fifo_rd_en = !fifo_empty && !flush
                      && ((3'(occ) + 3'(inflight)) < 3'(OUT_BUF_DEPTH));
  assign pop        = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (inflight),
    .push_data (fifo_r_data),
    .pop       (pop),
    .occ       (occ),
    .valid     (m_valid),
    .data      (m_data)
  );

`ifdef FIFO_RD_LAST_EN
  logic [BEAT_CNT_W-1:0] beat_cnt;

  assign m_last = m_valid && (beat_cnt == BEAT_CNT_W'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     beat_cnt <= '0;
    else if (flush) beat_cnt <= '0;
    else if (pop)   beat_cnt <= m_last ? '0 : beat_cnt + BEAT_CNT_W'(1);
  end
`else
  assign m_last = 1'b0;
`endif

endmodule
